spi_frame_transmitter: RTL

//  SPI mode-0 master transmitter: streams pixel bytes from an internal valid/ready source onto
//  spi_sclk/spi_mosi/spi_cs_n, MSB first, one frame of FRAME_BYTES bytes per CS-low window.

---
 rtl/spi_frame_transmitter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/spi_frame_transmitter.sv
// SPI mode-0 master that streams pixel bytes MSB first, one FRAME_BYTES frame per chip-select window.
// SCLK is derived from clk; the byte source is a plain valid/ready handshake.
module spi_frame_transmitter #(
    parameter int CLK_DIV     = 4,
    parameter int FRAME_BYTES = 1024,
    parameter int CS_SETUP    = 2,
    parameter int CS_HOLD     = 2,
    parameter int CS_GAP      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_pixel_data,
    input  logic       i_pixel_valid,
    output logic       o_pixel_ready,
    input  logic       i_abort,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       spi_cs_n
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int BC_W    = $clog2(FRAME_BYTES + 1);
    localparam int TMR_MAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                                  : ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [BC_W-1:0]  BYTE_LAST  = BC_W'(FRAME_BYTES - 1);
    localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(CS_HOLD - 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(CS_GAP - 1);
    localparam logic [TMR_W-1:0] GAP_PRE    = TMR_W'(CS_GAP - 2);

    logic [2:0]       state;
    logic [TMR_W-1:0] tmr;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [BC_W-1:0]  byte_cnt;
    logic             aborted;
    logic [7:0]       shreg;

    logic accept;
    logic abort_now;
    logic half_end;
    logic shift_bit;

    always_comb begin
        o_pixel_ready = (state == S_IDLE) || (state == S_LOAD);
        o_busy        = (state != S_IDLE);
        accept        = i_pixel_valid && o_pixel_ready;
        abort_now     = i_abort && (state != S_IDLE);
        half_end      = (div_cnt == DIV_LAST);
        shift_bit     = (state == S_SHIFT) && half_end && spi_sclk && (bit_cnt != 3'd7) && !abort_now;
    end

    // Shift register holds payload only; it is never observed before a byte is loaded.
    always_ff @(posedge clk) begin
        if (accept && !abort_now) begin
            shreg <= i_pixel_data;
        end else if (shift_bit) begin
            shreg <= {shreg[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            tmr          <= '0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            aborted      <= 1'b0;
            o_frame_done <= 1'b0;
            spi_sclk     <= 1'b0;
            spi_mosi     <= 1'b0;
            spi_cs_n     <= 1'b1;
        end else begin
            o_frame_done <= 1'b0;
            if (abort_now) begin
                state    <= S_GAP;
                tmr      <= '0;
                div_cnt  <= '0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                aborted  <= 1'b1;
                spi_sclk <= 1'b0;
                spi_mosi <= 1'b0;
                spi_cs_n <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            state    <= S_SETUP;
                            tmr      <= '0;
                            byte_cnt <= '0;
                            aborted  <= 1'b0;
                            spi_cs_n <= 1'b0;
                            spi_mosi <= i_pixel_data[7];
                        end
                    end
                    S_SETUP: begin
                        if (tmr == SETUP_LAST) begin
                            state   <= S_SHIFT;
                            div_cnt <= '0;
                            bit_cnt <= '0;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    S_SHIFT: begin
                        if (!half_end) begin
                            div_cnt <= div_cnt + 1'b1;
                        end else begin
                            div_cnt <= '0;
                            if (!spi_sclk) begin
                                spi_sclk <= 1'b1;
                            end else begin
                                // Falling edge: present the next bit, or close out the byte.
                                spi_sclk <= 1'b0;
                                if (bit_cnt == 3'd7) begin
                                    bit_cnt  <= '0;
                                    byte_cnt <= byte_cnt + 1'b1;
                                    if (byte_cnt == BYTE_LAST) begin
                                        state <= S_HOLD;
                                        tmr   <= '0;
                                    end else begin
                                        state <= S_LOAD;
                                    end
                                end else begin
                                    bit_cnt  <= bit_cnt + 1'b1;
                                    spi_mosi <= shreg[6];
                                end
                            end
                        end
                    end
                    S_LOAD: begin
                        if (accept) begin
                            state    <= S_SHIFT;
                            div_cnt  <= '0;
                            spi_mosi <= i_pixel_data[7];
                        end
                    end
                    S_HOLD: begin
                        if (tmr == HOLD_LAST) begin
                            state    <= S_GAP;
                            tmr      <= '0;
                            spi_cs_n <= 1'b1;
                            spi_mosi <= 1'b0;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    S_GAP: begin
                        // Registered pulse lands on the final gap cycle; aborted frames stay silent.
                        if ((tmr == GAP_PRE) && !aborted) begin
                            o_frame_done <= 1'b1;
                        end
                        if (tmr == GAP_LAST) begin
                            state <= S_IDLE;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
